// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, default reset PC, buffer entry layout, control states.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  // Entry layout {fault, pc[31:0], instr[31:0]}
  localparam int ENTRY_W   = 65;
  localparam int INSTR_LSB = 0;
  localparam int PC_LSB    = 32;
  localparam int FAULT_BIT = 64;

  typedef struct packed {
    logic        fault;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH_RUN,
    FETCH_FAULT,
    FETCH_HALT
  } fetch_state_t;

  function automatic fetch_entry_t make_entry(input logic fault, input logic [31:0] pc,
                                              input logic [31:0] instr);
    fetch_entry_t e;
    e.fault = fault;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer of DEPTH entries; flush empties it while a same-cycle pop still completes.
// With FETCH_PERF_EN defined the occupancy is exported as port count.
import fetch_unit_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] push_data,
  output logic [ENTRY_W-1:0] head,
  output logic               empty,
  output logic               full
`ifdef FETCH_PERF_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count_q;

  // A flush discards everything; the popped head was already consumed this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

`ifdef FETCH_PERF_EN
  assign count = count_q;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, redirect/misalignment handling and a small buffer toward decode.
// Optional performance counters are enabled with FETCH_PERF_EN.
import fetch_unit_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop, empty, full;
  fetch_entry_t push_entry, head_entry;

`ifdef FETCH_PERF_EN
  logic [$clog2(FIFO_DEPTH):0] occupancy;
`endif

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_data(push_entry),
    .head     (head_entry),
    .empty    (empty),
    .full     (full)
`ifdef FETCH_PERF_EN
    ,
    .count    (occupancy)
`endif
  );

  assign pop = out_valid & out_ready;

  // FETCH_FAULT queues the single fault marker after a misaligned redirect, then FETCH_HALT idles.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    push       = 1'b0;
    push_entry = make_entry(1'b0, pc_q, imem_rd);
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = (redirect_pc[1:0] == 2'b00) ? FETCH_RUN : FETCH_FAULT;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (!full || pop) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end
        end
        FETCH_FAULT: begin
          if (!full || pop) begin
            push       = 1'b1;
            push_entry = make_entry(1'b1, pc_q, NOP_INSTR);
            state_d    = FETCH_HALT;
          end
        end
        default: state_d = FETCH_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign out_valid    = ~empty;
  assign out_instr    = empty ? NOP_INSTR : head_entry.instr;
  assign out_pc       = empty ? 32'h0 : head_entry.pc;
  assign out_pc_plus4 = out_pc + 32'd4;
  assign out_fault    = ~empty & head_entry.fault;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  // Entries discarded by a redirect are everything buffered except a head popped that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (push && !push_entry.fault) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + 32'(occupancy) - 32'(pop);
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
